ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_tx.sv | 165 ++++++++++++++++
 tb/tb_ps2_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// PS/2-style device transmitter: serialises start, data (LSB first), odd-XOR parity and stop bits
// on SDA/SCL, with host inhibit handling, a post-frame guard time and registered status pulses.
module ps2_tx #(
  parameter int DP_size = 8,
  parameter int CLK_DIV = 4
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [DP_size-1:0] TX_DATA,
  input  logic               TX_VALID,
  input  logic               INHIBIT,
  output logic               TX_READY,
  output logic               SDA,
  output logic               SCL,
  output logic               DONE,
  output logic               ABORT
);

  localparam int NBITS   = DP_size + 3;
  localparam int BIT_LEN = 2 * CLK_DIV;
  localparam int BW      = $clog2(NBITS);
  localparam int PW      = $clog2(BIT_LEN);

  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [BW-1:0] PAR_BIT  = BW'(NBITS - 2);
  localparam logic [PW-1:0] PH_FALL  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_DONE  = PW'(BIT_LEN - 2);
  localparam logic [PW-1:0] PH_LAST  = PW'(BIT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XMIT  = 2'd1,
    GUARD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [NBITS-1:0]   frame_q, frame_d;
  logic               sda_q, sda_d;
  logic               scl_q, scl_d;
  logic               ready_q, ready_d;
  logic               armed_q, armed_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  logic accept;
  logic pre_parity;

  // armed_q keeps the first edge after reset from accepting before TX_READY has been shown.
  assign accept     = (state_q == IDLE) && armed_q && !INHIBIT && TX_VALID;
  assign pre_parity = (bit_q < PAR_BIT) || ((bit_q == PAR_BIT) && (phase_q < PH_HALF));

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    frame_d = frame_q;
    sda_d   = sda_q;
    scl_d   = scl_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = XMIT;
          bit_d   = '0;
          phase_d = '0;
          frame_d = {1'b1, ^TX_DATA, TX_DATA, 1'b0};
          sda_d   = 1'b0;
          scl_d   = 1'b1;
        end
      end

      XMIT: begin
        if (INHIBIT && pre_parity) begin
          state_d = IDLE;
          bit_d   = '0;
          phase_d = '0;
          sda_d   = 1'b1;
          scl_d   = 1'b1;
          abort_d = 1'b1;
        end else if (phase_q == PH_LAST) begin
          phase_d = '0;
          scl_d   = 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = GUARD;
            bit_d   = '0;
            sda_d   = 1'b1;
          end else begin
            bit_d   = bit_q + BW'(1);
            frame_d = frame_q >> 1;
            sda_d   = frame_q[1];
          end
        end else begin
          phase_d = phase_q + PW'(1);
          if (phase_q == PH_FALL) begin
            scl_d = 1'b0;
          end
        end
      end

      GUARD: begin
        sda_d  = 1'b1;
        scl_d  = 1'b1;
        done_d = (phase_q == PH_DONE);
        if (phase_q == PH_LAST) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        bit_d   = '0;
        phase_d = '0;
        sda_d   = 1'b1;
        scl_d   = 1'b1;
      end
    endcase

    ready_d = (state_d == IDLE) && !INHIBIT;
    armed_d = (state_d == IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the frame register is reset along with the control state; it is narrow, so this costs nothing.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      bit_q   <= '0;
      phase_q <= '0;
      frame_q <= '1;
      sda_q   <= 1'b1;
      scl_q   <= 1'b1;
      ready_q <= 1'b0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      sda_q   <= sda_d;
      scl_q   <= scl_d;
      ready_q <= ready_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign TX_READY = ready_q;
  assign SDA      = sda_q;
  assign SCL      = scl_q;
  assign DONE     = done_q;
  assign ABORT    = abort_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Randomised self-checking bench for ps2_tx: a cycle-indexed waveform model of each frame
// (bit index and phase from plain division) plus directed abort, inhibit, reset and chaining cases.
module tb_ps2_tx;

  localparam int DP    = 8;
  localparam int CD    = 4;
  localparam int N     = DP + 3;
  localparam int BL    = 2 * CD;
  localparam int XLEN  = N * BL;
  localparam int GLEN  = BL;
  localparam int PFALL = (N - 2) * BL + CD + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [DP-1:0] tx_data;
  logic          tx_valid;
  logic          inhibit;
  logic          tx_ready;
  logic          sda;
  logic          scl;
  logic          done;
  logic          abort;

  int n_vec = 0;
  int n_err = 0;

  ps2_tx #(.DP_size(DP), .CLK_DIV(CD)) dut (
    .CLOCK   (clock),
    .RESET   (reset),
    .TX_DATA (tx_data),
    .TX_VALID(tx_valid),
    .INHIBIT (inhibit),
    .TX_READY(tx_ready),
    .SDA     (sda),
    .SCL     (scl),
    .DONE    (done),
    .ABORT   (abort)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected frame: start 0, data LSB first, parity = odd count of ones, stop 1.
  function automatic logic [N-1:0] frame_of(input logic [DP-1:0] d);
    logic [N-1:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < DP; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[N-2] = (ones % 2 == 1);
    f[N-1] = 1'b1;
    return f;
  endfunction

  task automatic wait_ready();
    int i = 0;
    while (tx_ready !== 1'b1 && i < 200) begin
      @(negedge clock);
      i++;
    end
    check("ready_wait", tx_ready, 1);
  endtask

  // Presents a request; returns at the negedge of the first frame cycle.
  task automatic start_frame(input logic [DP-1:0] d);
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clock);
  endtask

  // Checks one frame cycle by cycle starting at its first cycle. inh_at>0 raises INHIBIT
  // during that frame cycle; chain keeps TX_VALID high with nxt queued as the next byte.
  task automatic run_frame(input logic [DP-1:0] d, input int inh_at, input bit chain,
                           input logic [DP-1:0] nxt, output logic [N-1:0] caught);
    logic [N-1:0] f = frame_of(d);
    bit   prev_scl = 1'b1;
    int   nf = 0;
    bit   aborting = (inh_at > 0) && (inh_at < PFALL);
    int   last = aborting ? inh_at : XLEN + GLEN;
    logic e_sda, e_scl, e_done;
    caught = '0;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) @(negedge clock);
      if (k <= XLEN) begin
        e_sda  = f[(k-1) / BL];
        e_scl  = ((k-1) % BL) < CD;
        e_done = 1'b0;
      end else begin
        e_sda  = 1'b1;
        e_scl  = 1'b1;
        e_done = (k == XLEN + GLEN);
      end
      check("sda", sda, e_sda);
      check("scl", scl, e_scl);
      check("done", done, e_done);
      check("abort_idle", abort, 0);
      check("ready_busy", tx_ready, 0);
      if (prev_scl && !scl) begin
        if (nf < N) caught[nf] = sda;
        nf++;
      end
      prev_scl = scl;
      if (chain) begin
        tx_valid = 1'b1;
        tx_data  = nxt;
      end else begin
        tx_valid = (k < XLEN && !aborting) ? 1'($urandom_range(0, 1)) : 1'b0;
        tx_data  = DP'($urandom);
      end
      if (k == inh_at) inhibit = 1'b1;
      if (k == inh_at + 1) inhibit = 1'b0;
    end
    if (aborting) begin
      @(negedge clock);
      check("abort_pulse", abort, 1);
      check("abort_sda", sda, 1);
      check("abort_scl", scl, 1);
      check("abort_no_done", done, 0);
      inhibit = 1'b0;
      @(negedge clock);
      check("abort_single", abort, 0);
      check("abort_ready", tx_ready, 1);
    end else begin
      check("fall_count", nf, N);
      check("frame_bits", caught, f);
      @(negedge clock);
      check("ready_after", tx_ready, 1);
      check("done_single", done, 0);
      if (chain) begin
        @(negedge clock);
        check("b2b_start_sda", sda, 0);
        check("b2b_start_ready", tx_ready, 0);
      end
    end
  endtask

  initial begin
    logic [N-1:0]  cap;
    logic [DP-1:0] d, d2;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    inhibit  = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_sda", sda, 1);
    check("rst_scl", scl, 1);
    check("rst_ready", tx_ready, 0);
    check("rst_done", done, 0);
    check("rst_abort", abort, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", tx_ready, 1);

    start_frame(8'hA5);
    run_frame(8'hA5, 0, 1'b0, '0, cap);
    check("seq_a5", cap, 11'h54A);

    start_frame(8'h01);
    run_frame(8'h01, 0, 1'b0, '0, cap);
    check("seq_01", cap, 11'h602);

    repeat (5) begin
      d = DP'($urandom);
      start_frame(d);
      run_frame(d, 0, 1'b0, '0, cap);
    end

    // INHIBIT during data bit 3 (frame bit 4), then on either side of the parity sample point.
    d = DP'($urandom);
    start_frame(d);
    run_frame(d, 4 * BL + 3, 1'b0, '0, cap);
    d = DP'($urandom);
    start_frame(d);
    run_frame(d, PFALL - 1, 1'b0, '0, cap);
    d = DP'($urandom);
    start_frame(d);
    run_frame(d, PFALL, 1'b0, '0, cap);

    wait_ready();
    d        = DP'($urandom);
    inhibit  = 1'b1;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("inh_sda", sda, 1);
      check("inh_scl", scl, 1);
      check("inh_ready", tx_ready, 0);
    end
    inhibit = 1'b0;
    @(negedge clock);
    run_frame(d, 0, 1'b0, '0, cap);

    // Back-to-back: second start bit appears one idle cycle after the guard time.
    d  = DP'($urandom);
    d2 = DP'($urandom);
    start_frame(d);
    run_frame(d, 0, 1'b1, d2, cap);
    run_frame(d2, 0, 1'b0, '0, cap);

    d = DP'($urandom);
    start_frame(d);
    tx_valid = 1'b0;
    repeat (CD) @(negedge clock);
    check("pre_rst_scl_low", scl, 0);
    #1 reset = 1'b1;
    #1;
    check("async_rst_sda", sda, 1);
    check("async_rst_scl", scl, 1);
    check("async_rst_ready", tx_ready, 0);
    repeat (3) @(negedge clock);
    check("rst_hold_done", done, 0);
    check("rst_hold_abort", abort, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst2", tx_ready, 1);
    start_frame(8'h3C);
    run_frame(8'h3C, 0, 1'b0, '0, cap);
    check("seq_3c", cap, frame_of(8'h3C));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
